// File: rtl/direction_ctrl.sv
// direction_ctrl: turns player 1 keyboard make events and debounced player 2
// buttons into queued turn requests, and commits one queued turn per game tick.
module direction_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [1:0]  P1_INIT_DIR     = 2'b01,
  parameter logic [1:0]  P2_INIT_DIR     = 2'b10
) (
  input  logic         clk_25MHz,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic [3:0]   key_in,
  input  logic         tick,
  input  logic         round_restart,
  output logic [1:0]   player1_dir,
  output logic [1:0]   player2_dir,
  output logic [1:0]   p1_qcount,
  output logic [1:0]   p2_qcount,
  output logic [3:0]   btn_level
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] dcnt_q [4];
  logic [CW-1:0] dcnt_d [4];
  logic [3:0]    btn_q, btn_d, btn_rise;

  logic          req_v   [2];
  logic [1:0]    req_dir [2];

  logic [1:0]    dir_q  [2];
  logic [1:0]    dir_d  [2];
  logic [1:0]    fifo_q [2][2];
  logic [1:0]    fifo_d [2][2];
  logic [1:0]    qcnt_q [2];
  logic [1:0]    qcnt_d [2];
  logic [1:0]    ref_dir [2];
  logic          accept [2];
  logic          pop    [2];
  logic [1:0]    post   [2];

  // Two-flop synchronizer for the raw player 2 buttons.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: count consecutive cycles that disagree with the level.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      dcnt_d[i] = '0;
      btn_d[i]  = btn_q[i];
      if (sync2_q[i] != btn_q[i]) begin
        if (dcnt_q[i] == CNT_LAST) begin
          btn_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce counters and levels; untouched by round_restart.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      for (int unsigned i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      btn_q <= btn_d;
      for (int unsigned i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Request decode: player 1 from make-event scancodes, player 2 from the
  // highest-priority rising button edge (rise is seen as the level commits).
  always_comb begin
    req_v[0]   = 1'b0;
    req_dir[0] = DIR_UP;
    if (key_valid && !last_change[8] && key_down[last_change]) begin
      unique case (last_change[7:0])
        8'h1D:   begin req_v[0] = 1'b1; req_dir[0] = DIR_UP;    end
        8'h1C:   begin req_v[0] = 1'b1; req_dir[0] = DIR_LEFT;  end
        8'h1B:   begin req_v[0] = 1'b1; req_dir[0] = DIR_DOWN;  end
        8'h23:   begin req_v[0] = 1'b1; req_dir[0] = DIR_RIGHT; end
        default: req_v[0] = 1'b0;
      endcase
    end

    btn_rise   = btn_d & ~btn_q;
    req_v[1]   = |btn_rise;
    req_dir[1] = DIR_UP;
    if (btn_rise[3])      req_dir[1] = DIR_UP;
    else if (btn_rise[2]) req_dir[1] = DIR_LEFT;
    else if (btn_rise[1]) req_dir[1] = DIR_DOWN;
    else if (btn_rise[0]) req_dir[1] = DIR_RIGHT;
  end

  // Per-player turn queue: the reference is taken before the pop, the pop
  // happens first, then the request lands in the first free slot after it.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      dir_d[p]     = dir_q[p];
      fifo_d[p][0] = fifo_q[p][0];
      fifo_d[p][1] = fifo_q[p][1];
      qcnt_d[p]    = qcnt_q[p];
      ref_dir[p]   = (qcnt_q[p] == 2'd0) ? dir_q[p] :
                     (qcnt_q[p] == 2'd1) ? fifo_q[p][0] : fifo_q[p][1];
      accept[p]    = req_v[p] && (req_dir[p] != ref_dir[p]) &&
                     (req_dir[p] != ~ref_dir[p]);
      pop[p]       = tick && (qcnt_q[p] != 2'd0);
      post[p]      = qcnt_q[p] - {1'b0, pop[p]};
      if (round_restart) begin
        dir_d[p]  = (p == 0) ? P1_INIT_DIR : P2_INIT_DIR;
        qcnt_d[p] = '0;
      end else begin
        if (pop[p]) begin
          dir_d[p]     = fifo_q[p][0];
          fifo_d[p][0] = fifo_q[p][1];
        end
        if (accept[p] && (post[p] < 2'd2)) begin
          fifo_d[p][post[p][0]] = req_dir[p];
          qcnt_d[p]             = post[p] + 2'd1;
        end else begin
          qcnt_d[p] = post[p];
        end
      end
    end
  end

  // Committed directions and queue storage.
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      dir_q[0] <= P1_INIT_DIR;
      dir_q[1] <= P2_INIT_DIR;
      for (int unsigned p = 0; p < 2; p++) begin
        fifo_q[p][0] <= '0;
        fifo_q[p][1] <= '0;
        qcnt_q[p]    <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        dir_q[p]     <= dir_d[p];
        fifo_q[p][0] <= fifo_d[p][0];
        fifo_q[p][1] <= fifo_d[p][1];
        qcnt_q[p]    <= qcnt_d[p];
      end
    end
  end

  assign player1_dir = dir_q[0];
  assign player2_dir = dir_q[1];
  assign p1_qcount   = qcnt_q[0];
  assign p2_qcount   = qcnt_q[1];
  assign btn_level   = btn_q;

endmodule

// File: doc/direction_ctrl.md
DIRECTION_CTRL -- requirements
Module: direction_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, which is the number of consecutive stable cycles needed to accept a new key_in level.
REQ-002 The block SHALL have parameter P1_INIT_DIR, default 2'b01, which is the player 1 direction after reset or restart.
REQ-003 The block SHALL have parameter P2_INIT_DIR, default 2'b10, which is the player 2 direction after reset or restart.
REQ-004 The block SHALL have port clk_25MHz, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe marking a keyboard event.
REQ-007 The block SHALL have port last_change, input, 9 bits: scancode of the event marked by key_valid.
REQ-008 The block SHALL have port key_down, input, 512 bits: current pressed state per scancode.
REQ-009 The block SHALL have port key_in, input, 4 bits: raw, asynchronous player 2 buttons ordered {up, left, down, right}.
REQ-010 The block SHALL have port tick, input, 1 bit: one-cycle game-step strobe, already synchronous to clk_25MHz.
REQ-011 The block SHALL have port round_restart, input, 1 bit: one-cycle strobe issued when a round ends.
REQ-012 The block SHALL have ports player1_dir and player2_dir, outputs, 2 bits each: committed directions.
REQ-013 The block SHALL have ports p1_qcount and p2_qcount, outputs, 2 bits each: pending-turn queue occupancy, range 0..2.
REQ-014 The block SHALL have port btn_level, output, 4 bits: debounced key_in levels, for the LEDs.

Function
REQ-015 Direction encoding SHALL be: 00 up, 01 right, 10 left, 11 down; the opposite of direction d is ~d.
REQ-016 A player 1 request SHALL be generated in the cycle where all of the following hold: key_valid=1, last_change[8]=0, key_down[last_change]=1, and last_change[7:0] is one of 1D (up), 1C (left), 1B (down), 23 (right).
REQ-017 Break events, extended codes, and all other scancodes SHALL be ignored.
REQ-018 key_in SHALL pass through a 2-flop synchronizer before debouncing.
REQ-019 Each key_in bit SHALL have its own debounce counter; btn_level[i] takes the synchronized value only after DEBOUNCE_CYCLES consecutive cycles differing from the current btn_level[i]; any bounce clears the counter.
REQ-020 A 0->1 transition of btn_level SHALL generate one player 2 request.
REQ-021 If several btn_level bits rise in the same cycle, only one player 2 request SHALL be generated, with priority up > left > down > right; the others are dropped.
REQ-022 Each player SHALL own a 2-entry FIFO of pending directions.
REQ-023 Each request SHALL be compared against a reference direction: the FIFO tail if the FIFO is non-empty, otherwise the current player_dir.
REQ-024 A request SHALL be rejected when it equals the reference or equals ~reference, i.e. no 180-degree reversal and no duplicate.
REQ-025 On tick with a non-empty FIFO, player_dir SHALL load the head on that edge, the head is popped, and the new value is visible in the next cycle.
REQ-026 On tick with an empty FIFO, player_dir SHALL be unchanged.
REQ-027 player_dir SHALL change only on tick, round_restart, or rst.
REQ-028 When tick and a request occur in the same cycle, the pop SHALL be performed first, the reference is taken from pre-pop state, and the request is accepted only if it passes REQ-024 and the post-pop occupancy is below 2.
REQ-029 If the post-pop occupancy is 2, the request SHALL be dropped silently and the FIFO contents are unchanged.
REQ-030 round_restart SHALL empty both FIFOs, load P1_INIT_DIR and P2_INIT_DIR, and discard any request and tick in the same cycle.
REQ-031 round_restart SHALL NOT affect the debounce state.
REQ-032 The two players SHALL be fully independent; simultaneous requests from both players are both processed.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While rst=1, and immediately on assertion regardless of clock, the block SHALL hold: player1_dir=P1_INIT_DIR, player2_dir=P2_INIT_DIR, both FIFOs empty, p1_qcount=p2_qcount=0, btn_level=0, debounce counters 0, synchronizers 0.
REQ-035 Reset asserted mid-debounce or with queued turns SHALL discard all pending state.

Verification
REQ-036 Queue fill: player1_dir=01, FIFO empty; W make event, then S make event, then A make event. Expected: p1_qcount=1 holding 00. S is rejected as the reversal of 00. A is accepted and p1_qcount=2. On 2 ticks player1_dir goes 00 then 10, and p1_qcount=0.
REQ-037 Reversal and duplicate rejection: player1_dir=01, FIFO empty; a left request, then a right request. Expected: both are rejected, p1_qcount=0, and player1_dir=01 after a tick.
REQ-038 Full queue with tick: queue holds {00, 10}; tick and an S make event in the same cycle. Expected: player1_dir=00 and the queue becomes {10, 11}. The same event without tick is dropped and the queue stays {10, 11}.
REQ-039 Debounce: DEBOUNCE_CYCLES=8; key_in[3] toggles every 3 cycles, then is held high. Expected: btn_level[3] rises exactly 8+2 cycles after the hold begins, one up request is generated, and p2_qcount=1.
REQ-040 Restart and reset: queues non-empty; round_restart together with tick. Expected: directions equal the INIT values and qcounts=0. rst asserted between clock edges forces the outputs to their reset values before the next edge.
